bru_exe: RTL
============

# bru_exe

Branch execute stage directly downstream of the branch issue stage. Accepts one registered operand bundle per cycle from issue over a valid/ready handshake and decodes the one-hot branch opcode. Evaluates the condition on two 64-bit operands and queues a single-bit taken/not-taken resolution, plus an illegal-opcode flag, in a small result FIFO. The FIFO drains to the branch-resolution consumer (jump control / branch history update) and can be flushed on pipeline kill.

## Interface
Parameters:
- EXE_DW, `BRU_EXEPARAM_DW (134), operand bundle width: {beq,bne,blt,bge,bltu,bgeu, op1[63:0], op2[63:0]}, MSB first
- RES_DEPTH, 2, result FIFO entries; power of two, ≥2
- RES_AW, 1, log2(RES_DEPTH)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- bru_exeparam_vaild  in  1  issue bundle valid
- bru_exeparam  in  EXE_DW  issue bundle
- bru_exeparam_ready  out  1  stage can accept this cycle; combinational from FIFO state only
- bru_flush  in  1  kill all queued and in-flight results
- bru_res_valid  out  1  result FIFO head valid
- bru_res_taken  out  1  head: branch taken
- bru_res_illegal  out  1  head: opcode field not exactly one-hot
- bru_res_ready  in  1  consumer accepts head

## Operation
- Accept: push = bru_exeparam_vaild & bru_exeparam_ready & ~bru_flush.
- bru_exeparam_ready = (count != RES_DEPTH). No pop-through: a full FIFO deasserts ready even when a pop happens in the same cycle.
- Compare on op1/op2:
  - beq: op1==op2
  - bne: op1!=op2
  - blt: $signed(op1)<$signed(op2)
  - bge: ~blt
  - bltu: unsigned op1<op2
  - bgeu: ~bltu
- illegal = popcount(opcode) != 1. When illegal, taken = 0.
- Pop: bru_res_valid & bru_res_ready & ~bru_flush.
- FIFO:
  - Write pointer wp, read pointer rp, RES_AW bits each, wrap modulo RES_DEPTH.
  - count is RES_AW+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- bru_res_valid = (count != 0). bru_res_taken and bru_res_illegal are the entry at rp; when count==0 they are 0.
- Flush: wp, rp and count reset to 0 at the next edge. The push or pop requested in the flush cycle is discarded. Flush takes priority over every other event.
- Reset: wp = rp = count = 0 and all entries 0. Reset values: bru_exeparam_ready=1, bru_res_valid=0, bru_res_taken=0, bru_res_illegal=0.
- Reset asserted mid-operation: all queued results are lost immediately (asynchronously); no partial state survives.

## Timing
- Bundle accepted at edge N appears at FIFO head with bru_res_valid=1 in cycle N+1 if the FIFO was empty. Latency is 1 cycle; no combinational path from bru_exeparam to bru_res_*.
- Throughput is 1 branch/cycle while the consumer holds bru_res_ready=1.
- With the consumer stalled, RES_DEPTH bundles are accepted, then ready drops in the cycle count reaches RES_DEPTH. Ready returns to 1 the cycle after the first pop.
- Issue side holds bundle and valid stable while ready=0. Exe samples only on valid & ready.
- The head stays stable until popped or flushed.

## Structure
- `BRU_EXEPARAM_DW and the opcode bit positions live in define.vh alongside the issue-side widths. Opcode order must match the issue stage's packing.
- Sub-module bru_cmp: purely combinational. Inputs are the 6-bit one-hot opcode, op1 and op2; outputs are taken and illegal.
- Pointer and count registers, plus per-entry storage, use gen_dffr with asynchronous active-low reset.

## Test plan
- Reset, then beq op1=op2=0x5, consumer ready → res_valid=1 one cycle after accept, taken=1, illegal=0; ready stays 1.
- blt op1=0xFFFF_FFFF_FFFF_FFFF, op2=1 → taken=1. bltu with the same operands → taken=0. bge and bgeu → taken 0 and 1 respectively.
- Consumer ready=0, three back-to-back bundles → first two accepted, ready=0 after the second, third held. Raise res_ready → results pop in order; third accepted the cycle after ready returns.
- FIFO full, push and pop requested together → push refused (ready=0), pop taken, count goes 2→1.
- Opcode 6'b000000 and 6'b110000 → illegal=1, taken=0 for both.
- Two entries queued, assert bru_flush with valid=1 → next cycle res_valid=0, count=0, flushed-cycle bundle not stored. Separately, assert RSTn low mid-burst → outputs take reset values immediately.

Source files
------------

// File: rtl/bru_exe_pkg.sv
// Shared widths, opcode bit positions and result payload for the branch execute stage.
// Opcode order must match the issue stage packing: {beq,bne,blt,bge,bltu,bgeu}.
package bru_exe_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned OPC_W           = 6;
  localparam int unsigned BRU_EXEPARAM_DW = OPC_W + 2 * XLEN;

  localparam int unsigned OPC_BEQ  = 5;
  localparam int unsigned OPC_BNE  = 4;
  localparam int unsigned OPC_BLT  = 3;
  localparam int unsigned OPC_BGE  = 2;
  localparam int unsigned OPC_BLTU = 1;
  localparam int unsigned OPC_BGEU = 0;

  typedef struct packed {
    logic taken;
    logic illegal;
  } bru_res_t;

endpackage

// File: rtl/bru_cmp.sv
// Combinational branch condition evaluation on a one-hot opcode.
// A non-one-hot opcode is flagged illegal and never reports taken.
module bru_cmp
  import bru_exe_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  output logic             taken,
  output logic             illegal
);

  logic eq;
  logic lt;
  logic ltu;

  always_comb begin
    eq      = (op1 == op2);
    lt      = ($signed(op1) < $signed(op2));
    ltu     = (op1 < op2);
    illegal = ($countones(opc) != 1);
    taken   = 1'b0;
    if (!illegal) begin
      taken = (opc[OPC_BEQ]  &  eq)  |
              (opc[OPC_BNE]  & ~eq)  |
              (opc[OPC_BLT]  &  lt)  |
              (opc[OPC_BGE]  & ~lt)  |
              (opc[OPC_BLTU] &  ltu) |
              (opc[OPC_BGEU] & ~ltu);
    end
  end

endmodule

// File: rtl/bru_exe.sv
// Branch execute stage: resolves one branch per cycle into a small result FIFO
// that drains to the branch-resolution consumer and is cleared by bru_flush.
module bru_exe
  import bru_exe_pkg::*;
#(
  parameter int unsigned EXE_DW    = BRU_EXEPARAM_DW,
  parameter int unsigned RES_DEPTH = 2,
  parameter int unsigned RES_AW    = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              bru_exeparam_vaild,
  input  logic [EXE_DW-1:0] bru_exeparam,
  output logic              bru_exeparam_ready,
  input  logic              bru_flush,
  output logic              bru_res_valid,
  output logic              bru_res_taken,
  output logic              bru_res_illegal,
  input  logic              bru_res_ready
);

  localparam int unsigned CNT_W = RES_AW + 1;

  logic [RES_AW-1:0] wp;
  logic [RES_AW-1:0] rp;
  logic [CNT_W-1:0]  count;
  bru_res_t          mem [RES_DEPTH];
  bru_res_t          res_new;
  bru_res_t          head;
  logic              cmp_taken;
  logic              cmp_illegal;
  logic              push;
  logic              pop;

  bru_cmp u_cmp (
    .opc     (bru_exeparam[EXE_DW-1 -: OPC_W]),
    .op1     (bru_exeparam[2*XLEN-1 -: XLEN]),
    .op2     (bru_exeparam[XLEN-1:0]),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Ready depends on occupancy only, so a full FIFO refuses even when popping.
  assign bru_exeparam_ready = (count != CNT_W'(RES_DEPTH));
  assign bru_res_valid      = (count != '0);
  assign head               = mem[rp];
  assign bru_res_taken      = bru_res_valid & head.taken;
  assign bru_res_illegal    = bru_res_valid & head.illegal;

  assign push    = bru_exeparam_vaild & bru_exeparam_ready & ~bru_flush;
  assign pop     = bru_res_valid & bru_res_ready & ~bru_flush;
  assign res_new = '{taken: cmp_taken, illegal: cmp_illegal};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bru_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= res_new;
        wp      <= wp + RES_AW'(1);
      end
      if (pop) begin
        rp <= rp + RES_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
